// File: rtl/issue_queue.sv
// -----------------------------------------------------------------------------
// issue_queue
//
// Out-of-order issue queue between rename/dispatch and the execute units.
// Renamed uops wait here until both source physical registers are ready.
// Writeback wakeup broadcasts are tracked, and the oldest ready uop, ordered by
// ROB age, is presented for issue. A pipeline flush either clears the whole
// queue (exception) or removes only the entries younger than a ROB id (branch
// mispredict).
//
// Optional feature (macro ISSUE_QUEUE_WAKEUP_BYPASS_EN):
//   defined   - same-cycle wakeup matches also count toward eligibility, so an
//               entry woken at cycle t can issue at cycle t.
//   undefined - eligibility uses registered ready bits only, so an entry woken
//               at cycle t can issue at cycle t+1 at the earliest.
//
// Ports:
//   clk, reset                 clock, asynchronous active-high reset
//   in_valid / in_ready        dispatch handshake
//   in_uop, in_info, in_imm    uop payload; in_info = {rob_id[6:0], rd_phy[5:0]}
//   in_rs1/in_rs2              source physical registers
//   in_rs1_rdy/in_rs2_rdy      source already available at dispatch
//   wk_valid, wk_phy           wakeup broadcast ports (6-bit phy reg per port)
//   out_valid / out_ready      issue handshake
//   out_uop/out_info/out_rs1/out_rs2/out_imm   fields of the selected entry
//   flush, flush_is_exception  flush request and kind
//   flush_rob_id               branch-failure boundary; younger entries drop
//   count                      number of valid entries
// -----------------------------------------------------------------------------
module issue_queue #(
    parameter int unsigned DEPTH        = 8,
    parameter int unsigned WAKEUP_PORTS = 2,
    parameter int unsigned UOP_W        = 8,
    parameter int unsigned IMM_W        = 32,
    localparam int unsigned PHY_W       = 6,
    localparam int unsigned ROB_W       = 7,
    localparam int unsigned INFO_W      = ROB_W + PHY_W,
    localparam int unsigned CNT_W       = $clog2(DEPTH + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    // dispatch side
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [UOP_W-1:0]                in_uop,
    input  logic [INFO_W-1:0]               in_info,
    input  logic [PHY_W-1:0]                in_rs1,
    input  logic [PHY_W-1:0]                in_rs2,
    input  logic                            in_rs1_rdy,
    input  logic                            in_rs2_rdy,
    input  logic [IMM_W-1:0]                in_imm,
    // writeback wakeup broadcast
    input  logic [WAKEUP_PORTS-1:0]         wk_valid,
    input  logic [WAKEUP_PORTS*PHY_W-1:0]   wk_phy,
    // issue side
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [UOP_W-1:0]                out_uop,
    output logic [INFO_W-1:0]               out_info,
    output logic [PHY_W-1:0]                out_rs1,
    output logic [PHY_W-1:0]                out_rs2,
    output logic [IMM_W-1:0]                out_imm,
    // flush
    input  logic                            flush,
    input  logic                            flush_is_exception,
    input  logic [ROB_W-1:0]                flush_rob_id,
    // occupancy
    output logic [CNT_W-1:0]                count
);

    // Returns 1 when b is strictly younger than a. ROB ids live in a 64-entry
    // window; the top bit flips on every wrap, so when the top bits differ the
    // comparison of the low bits is inverted.
    function automatic logic compare_rob_age(input logic [ROB_W-1:0] a,
                                             input logic [ROB_W-1:0] b);
        if (a[ROB_W-1] == b[ROB_W-1]) begin
            return a[ROB_W-2:0] < b[ROB_W-2:0];
        end else begin
            return a[ROB_W-2:0] > b[ROB_W-2:0];
        end
    endfunction

    // Any wakeup port broadcasting this physical register this cycle.
    function automatic logic wake_hit(input logic [PHY_W-1:0]              phy,
                                      input logic [WAKEUP_PORTS-1:0]       vld,
                                      input logic [WAKEUP_PORTS*PHY_W-1:0] tags);
        logic hit;
        hit = 1'b0;
        for (int unsigned k = 0; k < WAKEUP_PORTS; k++) begin
            if (vld[k] && (tags[k*PHY_W +: PHY_W] == phy)) begin
                hit = 1'b1;
            end
        end
        return hit;
    endfunction

    // -------------------------------------------------------------------------
    // Entry storage
    // -------------------------------------------------------------------------
    logic [DEPTH-1:0]   valid_q,   valid_d;
    logic [DEPTH-1:0]   rs1_rdy_q, rs1_rdy_d;
    logic [DEPTH-1:0]   rs2_rdy_q, rs2_rdy_d;
    logic [ROB_W-1:0]   rob_q  [DEPTH];
    logic [PHY_W-1:0]   rd_q   [DEPTH];
    logic [UOP_W-1:0]   uop_q  [DEPTH];
    logic [PHY_W-1:0]   rs1_q  [DEPTH];
    logic [PHY_W-1:0]   rs2_q  [DEPTH];
    logic [IMM_W-1:0]   imm_q  [DEPTH];
    logic [CNT_W-1:0]   count_q, count_d;

    // -------------------------------------------------------------------------
    // Wakeup matching for resident entries and for the incoming uop
    // -------------------------------------------------------------------------
    logic [DEPTH-1:0]   rs1_wake;
    logic [DEPTH-1:0]   rs2_wake;
    logic               in_rs1_wake;
    logic               in_rs2_wake;

    always_comb begin
        rs1_wake = '0;
        rs2_wake = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            rs1_wake[i] = wake_hit(rs1_q[i], wk_valid, wk_phy);
            rs2_wake[i] = wake_hit(rs2_q[i], wk_valid, wk_phy);
        end
        in_rs1_wake = wake_hit(in_rs1, wk_valid, wk_phy);
        in_rs2_wake = wake_hit(in_rs2, wk_valid, wk_phy);
    end

    // -------------------------------------------------------------------------
    // Eligibility
    // -------------------------------------------------------------------------
    logic [DEPTH-1:0]   eligible;

`ifdef ISSUE_QUEUE_WAKEUP_BYPASS_EN
    // Same-cycle wakeups count, giving zero-cycle wakeup-to-issue.
    assign eligible = valid_q & (rs1_rdy_q | rs1_wake) & (rs2_rdy_q | rs2_wake);
`else
    assign eligible = valid_q & rs1_rdy_q & rs2_rdy_q;
`endif

    // -------------------------------------------------------------------------
    // Oldest-eligible selection: an entry wins when every other eligible entry
    // is younger than it. ROB ids are unique, so at most one bit is set.
    // -------------------------------------------------------------------------
    logic [DEPTH-1:0]   sel_oh;
    logic               any_eligible;

    always_comb begin
        sel_oh = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            sel_oh[i] = eligible[i];
            for (int unsigned j = 0; j < DEPTH; j++) begin
                if ((j != i) && eligible[j] && !compare_rob_age(rob_q[i], rob_q[j])) begin
                    sel_oh[i] = 1'b0;
                end
            end
        end
    end

    assign any_eligible = |eligible;

    // -------------------------------------------------------------------------
    // Issue outputs: one-hot AND-OR mux over the entries
    // -------------------------------------------------------------------------
    logic [ROB_W-1:0]   sel_rob;
    logic [PHY_W-1:0]   sel_rd;

    always_comb begin
        out_uop = '0;
        out_rs1 = '0;
        out_rs2 = '0;
        out_imm = '0;
        sel_rob = '0;
        sel_rd  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (sel_oh[i]) begin
                out_uop = out_uop | uop_q[i];
                out_rs1 = out_rs1 | rs1_q[i];
                out_rs2 = out_rs2 | rs2_q[i];
                out_imm = out_imm | imm_q[i];
                sel_rob = sel_rob | rob_q[i];
                sel_rd  = sel_rd  | rd_q[i];
            end
        end
    end

    assign out_info  = {sel_rob, sel_rd};
    assign out_valid = any_eligible && !flush;

    // -------------------------------------------------------------------------
    // Dispatch side
    // -------------------------------------------------------------------------
    // A slot freed by this cycle's issue is not reusable until the next cycle,
    // which keeps in_ready independent of out_ready.
    assign in_ready = (count_q < CNT_W'(DEPTH)) && !flush;
    assign count    = count_q;

    logic               dispatch_fire;
    logic               issue_fire;
    logic [DEPTH-1:0]   alloc_oh;
    logic               alloc_found;

    assign dispatch_fire = in_valid && in_ready;
    assign issue_fire    = out_valid && out_ready;

    // Lowest-index free slot.
    always_comb begin
        alloc_oh    = '0;
        alloc_found = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (!valid_q[i] && !alloc_found) begin
                alloc_oh[i] = 1'b1;
                alloc_found = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // Next-state: wakeup, issue, dispatch, then flush overrides validity
    // -------------------------------------------------------------------------
    always_comb begin
        valid_d   = valid_q;
        // Wakeups apply to every slot; stale bits in invalid slots are
        // overwritten on allocation.
        rs1_rdy_d = rs1_rdy_q | rs1_wake;
        rs2_rdy_d = rs2_rdy_q | rs2_wake;

        if (issue_fire) begin
            valid_d = valid_d & ~sel_oh;
        end

        if (dispatch_fire) begin
            valid_d   = valid_d | alloc_oh;
            // Merge a same-cycle wakeup so it is never lost.
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (alloc_oh[i]) begin
                    rs1_rdy_d[i] = in_rs1_rdy || in_rs1_wake;
                    rs2_rdy_d[i] = in_rs2_rdy || in_rs2_wake;
                end
            end
        end

        // in_ready and out_valid are already gated by flush, so neither
        // dispatch nor issue can fire here; flush only has to prune validity.
        if (flush) begin
            if (flush_is_exception) begin
                valid_d = '0;
            end else begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (compare_rob_age(flush_rob_id, rob_q[i])) begin
                        valid_d[i] = 1'b0;
                    end
                end
            end
        end

        count_d = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            count_d = count_d + CNT_W'(valid_d[i]);
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q   <= '0;
            rs1_rdy_q <= '0;
            rs2_rdy_q <= '0;
            count_q   <= '0;
        end else begin
            valid_q   <= valid_d;
            rs1_rdy_q <= rs1_rdy_d;
            rs2_rdy_q <= rs2_rdy_d;
            count_q   <= count_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                rob_q[i] <= '0;
                rd_q[i]  <= '0;
                uop_q[i] <= '0;
                rs1_q[i] <= '0;
                rs2_q[i] <= '0;
                imm_q[i] <= '0;
            end
        end else if (dispatch_fire) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (alloc_oh[i]) begin
                    rob_q[i] <= in_info[INFO_W-1:PHY_W];
                    rd_q[i]  <= in_info[PHY_W-1:0];
                    uop_q[i] <= in_uop;
                    rs1_q[i] <= in_rs1;
                    rs2_q[i] <= in_rs2;
                    imm_q[i] <= in_imm;
                end
            end
        end
    end

endmodule

// File: tb/tb_issue_queue.sv
// Self-checking bench for issue_queue. The reference model keeps the resident
// uops as an unordered list and picks the oldest ready one using modular ROB
// distance, independent of slot positions inside the design.
module tb_issue_queue;

    localparam int DEPTH = 8;
    localparam int WP    = 2;

`ifdef ISSUE_QUEUE_WAKEUP_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_uop;
    logic [12:0]  in_info;
    logic [5:0]   in_rs1, in_rs2;
    logic         in_rs1_rdy, in_rs2_rdy;
    logic [31:0]  in_imm;
    logic [WP-1:0]   wk_valid;
    logic [WP*6-1:0] wk_phy;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_uop;
    logic [12:0]  out_info;
    logic [5:0]   out_rs1, out_rs2;
    logic [31:0]  out_imm;
    logic         flush, flush_is_exception;
    logic [6:0]   flush_rob_id;
    logic [3:0]   count;

    always #5 clk = ~clk;

    issue_queue #(
        .DEPTH        (DEPTH),
        .WAKEUP_PORTS (WP)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .in_valid           (in_valid),
        .in_ready           (in_ready),
        .in_uop             (in_uop),
        .in_info            (in_info),
        .in_rs1             (in_rs1),
        .in_rs2             (in_rs2),
        .in_rs1_rdy         (in_rs1_rdy),
        .in_rs2_rdy         (in_rs2_rdy),
        .in_imm             (in_imm),
        .wk_valid           (wk_valid),
        .wk_phy             (wk_phy),
        .out_valid          (out_valid),
        .out_ready          (out_ready),
        .out_uop            (out_uop),
        .out_info           (out_info),
        .out_rs1            (out_rs1),
        .out_rs2            (out_rs2),
        .out_imm            (out_imm),
        .flush              (flush),
        .flush_is_exception (flush_is_exception),
        .flush_rob_id       (flush_rob_id),
        .count              (count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // ---------------------------------------------------------------- model
    typedef struct {
        logic [6:0]  rob;
        logic [5:0]  rd;
        logic [7:0]  uop;
        logic [5:0]  rs1;
        logic [5:0]  rs2;
        bit          r1;
        bit          r2;
        logic [31:0] imm;
    } ent_t;

    ent_t mq[$];
    bit   e_in_ready;
    bit   e_out_valid;
    int   e_sel;

    // b strictly younger than a: forward distance a->b within 1..63.
    function automatic bit younger(input logic [6:0] a, input logic [6:0] b);
        int d;
        d = (int'(b) - int'(a) + 128) % 128;
        return (d >= 1) && (d <= 63);
    endfunction

    function automatic bit woken(input logic [5:0] phy);
        for (int p = 0; p < WP; p++) begin
            if (wk_valid[p] && (wk_phy[p*6 +: 6] == phy)) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit ready_now(input ent_t e);
        if (BYP) return (e.r1 || woken(e.rs1)) && (e.r2 || woken(e.rs2));
        return e.r1 && e.r2;
    endfunction

    function automatic ent_t apply_wake(input ent_t e);
        ent_t n;
        n = e;
        n.r1 = e.r1 || woken(e.rs1);
        n.r2 = e.r2 || woken(e.rs2);
        return n;
    endfunction

    task automatic model_eval();
        e_in_ready = (mq.size() < DEPTH) && !flush;
        e_sel = -1;
        for (int i = 0; i < mq.size(); i++) begin
            if (ready_now(mq[i])) begin
                bit best;
                best = 1'b1;
                for (int j = 0; j < mq.size(); j++) begin
                    if (j != i && ready_now(mq[j]) && !younger(mq[i].rob, mq[j].rob)) best = 1'b0;
                end
                if (best) e_sel = i;
            end
        end
        e_out_valid = (e_sel >= 0) && !flush;
    endtask

    task automatic model_update();
        ent_t nq[$];
        ent_t ne;
        if (flush) begin
            if (!flush_is_exception) begin
                foreach (mq[i]) begin
                    if (!younger(flush_rob_id, mq[i].rob)) nq.push_back(apply_wake(mq[i]));
                end
            end
        end else begin
            foreach (mq[i]) begin
                if (!(e_out_valid && out_ready && i == e_sel)) nq.push_back(apply_wake(mq[i]));
            end
            if (in_valid && e_in_ready) begin
                ne.rob = in_info[12:6];
                ne.rd  = in_info[5:0];
                ne.uop = in_uop;
                ne.rs1 = in_rs1;
                ne.rs2 = in_rs2;
                ne.r1  = in_rs1_rdy || woken(in_rs1);
                ne.r2  = in_rs2_rdy || woken(in_rs2);
                ne.imm = in_imm;
                nq.push_back(ne);
            end
        end
        mq = nq;
    endtask

    // Sample point: mid-cycle, model evaluated against the held inputs.
    task automatic sample();
        @(negedge clk);
        model_eval();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // -------------------------------------------------------------- drivers
    task automatic idle();
        in_valid = 0; in_uop = '0; in_info = '0; in_rs1 = '0; in_rs2 = '0;
        in_rs1_rdy = 0; in_rs2_rdy = 0; in_imm = '0;
        wk_valid = '0; wk_phy = '0; out_ready = 0;
        flush = 0; flush_is_exception = 0; flush_rob_id = '0;
    endtask

    task automatic set_dispatch(input logic [6:0] rob, input logic [5:0] rs1, input bit r1,
                                input logic [5:0] rs2, input bit r2);
        in_valid   = 1;
        in_info    = {rob, rob[5:0]};
        in_uop     = 8'($urandom);
        in_imm     = $urandom;
        in_rs1     = rs1;
        in_rs2     = rs2;
        in_rs1_rdy = r1;
        in_rs2_rdy = r2;
    endtask

    task automatic clear_queue();
        idle();
        flush = 1; flush_is_exception = 1;
        sample();
        tick();
        idle();
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        clear_queue();
        set_dispatch(7'd1, 6'd1, 1, 6'd2, 1); sample(); tick();
        set_dispatch(7'd2, 6'd3, 1, 6'd4, 1); sample(); tick();
        idle();
        sample();
        n_cmp++;
        if (count !== 4'd2) begin
            n_bad++; $display("FAIL reset_pre_count got=%0d want=2", count);
        end
        @(posedge clk);
        #2 reset = 1;
        #1;
        mq.delete();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_out_valid got=%b want=0", out_valid);
        end
        n_cmp++;
        if (count !== 4'd0) begin
            n_bad++; $display("FAIL reset_count got=%0d want=0", count);
        end
        @(posedge clk);
        #1 reset = 0;
        sample();
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready);
        end
        tick();
    endtask

    task automatic test_age_order();
        logic [6:0] robs[3];
        logic [6:0] exp_rob[3];
        robs    = '{7'd5, 7'd3, 7'd7};
        exp_rob = '{7'd3, 7'd5, 7'd7};
        clear_queue();
        for (int k = 0; k < 3; k++) begin
            set_dispatch(robs[k], 6'(k), 1, 6'(k + 8), 1);
            sample(); tick();
        end
        idle();
        out_ready = 1;
        for (int k = 0; k < 3; k++) begin
            sample();
            n_cmp++;
            if (out_valid !== 1'b1 || out_info[12:6] !== exp_rob[k]) begin
                n_bad++;
                $display("FAIL age_order[%0d] got=%b/%0d want=1/%0d",
                         k, out_valid, out_info[12:6], exp_rob[k]);
            end
            tick();
        end
        sample();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL age_order_drained got=%b want=0", out_valid);
        end
        tick();
    endtask

    task automatic test_wrap();
        clear_queue();
        set_dispatch(7'h41, 6'd1, 1, 6'd2, 1); sample(); tick();
        set_dispatch(7'h3E, 6'd3, 1, 6'd4, 1); sample(); tick();
        idle();
        out_ready = 1;
        sample();
        n_cmp++;
        if (out_valid !== 1'b1 || out_info[12:6] !== 7'h3E) begin
            n_bad++; $display("FAIL wrap_first got=%b/%h want=1/3e", out_valid, out_info[12:6]);
        end
        tick();
        sample();
        n_cmp++;
        if (out_valid !== 1'b1 || out_info[12:6] !== 7'h41) begin
            n_bad++; $display("FAIL wrap_second got=%b/%h want=1/41", out_valid, out_info[12:6]);
        end
        tick();
    endtask

    task automatic test_wakeup();
        clear_queue();
        set_dispatch(7'd9, 6'd12, 0, 6'd13, 1); sample(); tick();
        idle();
        sample();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL wake_waiting got=%b want=0", out_valid);
        end
        tick();
        wk_valid = 2'b01; wk_phy = {6'd0, 6'd12};
        sample();
        n_cmp++;
        if (out_valid !== BYP) begin
            n_bad++; $display("FAIL wake_same_cycle got=%b want=%b", out_valid, BYP);
        end
        tick();
        idle();
        out_ready = 1;
        sample();
        n_cmp++;
        if (out_valid !== 1'b1 || out_info[12:6] !== 7'd9) begin
            n_bad++; $display("FAIL wake_next_cycle got=%b/%0d want=1/9", out_valid, out_info[12:6]);
        end
        tick();
        // Wakeup coinciding with dispatch must be captured.
        idle();
        set_dispatch(7'd20, 6'd30, 0, 6'd31, 0);
        wk_valid = 2'b11; wk_phy = {6'd31, 6'd30};
        sample();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++; $display("FAIL wake_dispatch_cycle got=%b want=0", out_valid);
        end
        tick();
        idle();
        sample();
        n_cmp++;
        if (out_valid !== 1'b1 || out_info[12:6] !== 7'd20) begin
            n_bad++; $display("FAIL wake_at_dispatch got=%b/%0d want=1/20", out_valid, out_info[12:6]);
        end
        tick();
    endtask

    task automatic test_branch_flush();
        clear_queue();
        set_dispatch(7'd10, 6'd40, 0, 6'd41, 1); sample(); tick();
        set_dispatch(7'd11, 6'd42, 0, 6'd43, 0); sample(); tick();
        set_dispatch(7'd12, 6'd44, 0, 6'd45, 0); sample(); tick();
        idle();
        set_dispatch(7'd13, 6'd1, 1, 6'd2, 1);
        flush = 1; flush_is_exception = 0; flush_rob_id = 7'd11;
        wk_valid = 2'b10; wk_phy = {6'd40, 6'd0};
        out_ready = 1;
        sample();
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL flush_cycle_gating got=%b/%b want=0/0", in_ready, out_valid);
        end
        tick();
        idle();
        out_ready = 1;
        wk_valid = 2'b11; wk_phy = {6'd43, 6'd42};
        sample();
        n_cmp++;
        if (count !== 4'd2) begin
            n_bad++; $display("FAIL flush_count got=%0d want=2", count);
        end
        n_cmp++;
        if (out_valid !== 1'b1 || out_info[12:6] !== 7'd10) begin
            n_bad++; $display("FAIL flush_keep_wake got=%b/%0d want=1/10", out_valid, out_info[12:6]);
        end
        tick();
        wk_valid = 2'b11; wk_phy = {6'd45, 6'd44};
        sample();
        n_cmp++;
        if (out_valid !== 1'b1 || out_info[12:6] !== 7'd11) begin
            n_bad++; $display("FAIL flush_boundary got=%b/%0d want=1/11", out_valid, out_info[12:6]);
        end
        tick();
        idle();
        sample();
        n_cmp++;
        if (out_valid !== 1'b0 || count !== 4'd0) begin
            n_bad++;
            $display("FAIL flush_younger_gone got=%b/%0d want=0/0", out_valid, count);
        end
        tick();
    endtask

    task automatic test_full();
        clear_queue();
        for (int k = 0; k < DEPTH; k++) begin
            set_dispatch(7'(30 + k), 6'(k), 1, 6'(k + 16), 1);
            sample(); tick();
        end
        idle();
        set_dispatch(7'd50, 6'd1, 1, 6'd2, 1);
        out_ready = 1;
        sample();
        n_cmp++;
        if (count !== 4'd8 || in_ready !== 1'b0) begin
            n_bad++; $display("FAIL full_ready got=%0d/%b want=8/0", count, in_ready);
        end
        n_cmp++;
        if (out_valid !== 1'b1 || out_info[12:6] !== 7'd30) begin
            n_bad++; $display("FAIL full_issue got=%b/%0d want=1/30", out_valid, out_info[12:6]);
        end
        tick();
        idle();
        sample();
        n_cmp++;
        if (count !== 4'd7) begin
            n_bad++; $display("FAIL full_no_reuse got=%0d want=7", count);
        end
        tick();
        flush = 1; flush_is_exception = 1;
        sample(); tick();
        idle();
        sample();
        n_cmp++;
        if (count !== 4'd0) begin
            n_bad++; $display("FAIL exc_flush_count got=%0d want=0", count);
        end
        tick();
    endtask

    task automatic test_random();
        logic [6:0] next_rob;
        bit         too_old;
        int         d;
        clear_queue();
        next_rob = 7'h30;
        for (int cyc = 0; cyc < 600; cyc++) begin
            idle();
            if ($urandom_range(3) != 0) begin
                set_dispatch(next_rob, 6'($urandom_range(15)), ($urandom_range(2) == 0),
                             6'($urandom_range(15)), ($urandom_range(2) == 0));
            end
            for (int p = 0; p < WP; p++) begin
                wk_valid[p]      = $urandom_range(1);
                wk_phy[p*6 +: 6] = 6'($urandom_range(15));
            end
            out_ready = ($urandom_range(3) != 0);
            too_old = 1'b0;
            foreach (mq[i]) begin
                d = (int'(next_rob) - int'(mq[i].rob) + 128) % 128;
                if (d > 40) too_old = 1'b1;
            end
            case ($urandom_range(24))
                0: begin flush = 1; flush_is_exception = 1; end
                1: if (mq.size() > 0) begin
                    flush = 1;
                    flush_rob_id = mq[$urandom_range(mq.size() - 1)].rob;
                end
                default: ;
            endcase
            if (too_old) begin flush = 1; flush_is_exception = 1; end
            sample();
            n_cmp++;
            if (in_ready !== e_in_ready) begin
                n_bad++; $display("FAIL rand_in_ready cyc=%0d got=%b want=%b", cyc, in_ready, e_in_ready);
            end
            n_cmp++;
            if (count !== 4'(mq.size())) begin
                n_bad++; $display("FAIL rand_count cyc=%0d got=%0d want=%0d", cyc, count, mq.size());
            end
            n_cmp++;
            if (out_valid !== e_out_valid) begin
                n_bad++; $display("FAIL rand_out_valid cyc=%0d got=%b want=%b", cyc, out_valid, e_out_valid);
            end
            if (e_out_valid) begin
                n_cmp++;
                if (out_info !== {mq[e_sel].rob, mq[e_sel].rd} || out_uop !== mq[e_sel].uop ||
                    out_rs1 !== mq[e_sel].rs1 || out_rs2 !== mq[e_sel].rs2 ||
                    out_imm !== mq[e_sel].imm) begin
                    n_bad++;
                    $display("FAIL rand_fields cyc=%0d got rob=%h uop=%h imm=%h want rob=%h uop=%h imm=%h",
                             cyc, out_info[12:6], out_uop, out_imm,
                             mq[e_sel].rob, mq[e_sel].uop, mq[e_sel].imm);
                end
            end
            if (in_valid && e_in_ready) next_rob = next_rob + 7'(1 + $urandom_range(1));
            tick();
        end
    endtask

    initial begin
        idle();
        reset = 1;
        repeat (2) @(posedge clk);
        #1 reset = 0;
        test_reset();
        test_age_order();
        test_wrap();
        test_wakeup();
        test_branch_flush();
        test_full();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
